load_store_unit: RTL and testbench

CPU-side initiator for data memory accesses in the MEM stage. It accepts one load or store from the pipeline and checks alignment and size. Legal accesses are driven onto a word-wide, byte-enabled req/ack data bus. Load data is returned aligned and sign- or zero-extended, and faults (misalignment, illegal size, bus timeout) are reported as an exception with the response.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator with a req/ack byte-enabled data bus.
// Optional bus-timeout fault is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        exception,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [15:0] LP_TO = 16'(TIMEOUT);

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_a;
`ifdef LSU_TIMEOUT_EN
    logic [15:0] r_wait;
`else
    logic        w_unused_to;
    assign w_unused_to = ^LP_TO;
`endif

    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rdata;

    assign w_fault = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_a)
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            2'd3:    w_byte = bus_rdata[31:24];
            default: ;
        endcase
    end

    // Halfword offset is 0 or 2 here; odd offsets fault before the bus.
    assign w_half = r_a[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        w_rdata = bus_rdata;
        case (r_size)
            2'b00:   w_rdata = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_rdata = {{16{r_sign & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_size    <= 2'b00;
            r_sign    <= 1'b0;
            r_a       <= 2'b00;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            exception <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            r_wait    <= 16'd0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_size    <= req_size;
                        r_sign    <= req_sign;
                        r_a       <= req_addr[1:0];
                        if (w_fault) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            exception <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            r_state   <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= req_write;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= w_be;
                            bus_wdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                            r_wait    <= 16'd0;
`endif
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        r_state   <= S_RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        exception <= 1'b0;
                        rsp_rdata <= bus_we ? 32'd0 : w_rdata;
`ifdef LSU_TIMEOUT_EN
                    end else if (r_wait + 16'd1 == LP_TO) begin
                        r_state   <= S_RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        exception <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end else begin
                        r_wait    <= r_wait + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    exception <= 1'b0;
                    rsp_rdata <= 32'd0;
                    req_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit.
// Timeout scenario follows LSU_TIMEOUT_EN like the design.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exception;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .exception(exception),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] ad);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        return (ad % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] ad);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (ad % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return 32'(wd[7:0]) * 32'h01010101;
        if (sz == 2'b01) return 32'(wd[15:0]) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] ad, input logic [31:0] rw);
        int n;
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 2'b10) return rw;
        n = 8 << sz;
        mask = (32'd1 << n) - 32'd1;
        v = (rw >> (8 * (ad % 4))) & mask;
        if (sg && v[n-1]) v = v | ~mask;
        return v;
    endfunction

    // Starts at a negedge; returns at the negedge of cycle 1.
    task automatic start_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] ad, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = ad;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] ad, input logic [31:0] wd,
                             input logic [31:0] rd, input int k,
                             output logic [31:0] got);
        logic f;
        logic [31:0] exp_rd;
        f = m_fault(sz, ad);
        exp_rd = w ? 32'd0 : m_rdata(sz, sg, ad, rd);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before act=%b exp=1", req_ready);
        end
        start_req(w, sz, sg, ad, wd);
        if (f) begin
            checks++;
            if ({rsp_valid, exception, bus_req} !== 3'b110) begin
                failures++;
                $display("FAIL fault_rsp act=%b%b%b exp=110",
                         rsp_valid, exception, bus_req);
            end
            checks++;
            if (rsp_rdata !== 32'd0) begin
                failures++;
                $display("FAIL fault_rdata act=%h exp=0", rsp_rdata);
            end
            got = rsp_rdata;
        end else begin
            for (int i = 1; i <= k; i++) begin
                if (i > 1) @(negedge clk);
                checks++;
                if ({bus_req, rsp_valid, bus_we} !== {2'b10, w}) begin
                    failures++;
                    $display("FAIL bus_ctl act=%b%b%b exp=10%b",
                             bus_req, rsp_valid, bus_we, w);
                end
                checks++;
                if (bus_addr !== {ad[31:2], 2'b00} || bus_be !== m_be(sz, ad)) begin
                    failures++;
                    $display("FAIL bus_addr_be act=%h/%b exp=%h/%b",
                             bus_addr, bus_be, {ad[31:2], 2'b00}, m_be(sz, ad));
                end
                if (w) begin
                    checks++;
                    if (bus_wdata !== m_wdata(sz, wd)) begin
                        failures++;
                        $display("FAIL bus_wdata act=%h exp=%h",
                                 bus_wdata, m_wdata(sz, wd));
                    end
                end
                if (i == k) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
            end
            @(posedge clk);
            #1 bus_ack = 1'b0;
            bus_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({rsp_valid, exception, bus_req} !== 3'b100) begin
                failures++;
                $display("FAIL good_rsp act=%b%b%b exp=100",
                         rsp_valid, exception, bus_req);
            end
            checks++;
            if (rsp_rdata !== exp_rd) begin
                failures++;
                $display("FAIL rsp_rdata act=%h exp=%h", rsp_rdata, exp_rd);
            end
            got = rsp_rdata;
        end
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL ready_after act=%b%b exp=10", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({req_ready, bus_req, bus_we, rsp_valid, exception} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctl act=%b%b%b%b%b exp=10000",
                     req_ready, bus_req, bus_we, rsp_valid, exception);
        end
        checks++;
        if ({bus_addr, bus_be, bus_wdata, rsp_rdata} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data act=%h/%b/%h/%h exp=0",
                     bus_addr, bus_be, bus_wdata, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] got;
        do_access(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0, 2, got);
        do_access(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80112233, 1, got);
        checks++;
        if (got !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_signed act=%h exp=ffffff80", got);
        end
        do_access(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80112233, 3, got);
        checks++;
        if (got !== 32'h00000080) begin
            failures++;
            $display("FAIL lb_unsigned act=%h exp=00000080", got);
        end
        do_access(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 32'h9ABC1234, 1, got);
        checks++;
        if (got !== 32'hFFFF9ABC) begin
            failures++;
            $display("FAIL lh_signed act=%h exp=ffff9abc", got);
        end
        do_access(1'b1, 2'b01, 1'b0, 32'h1002, 32'h00005678, 32'h0, 1, got);
    endtask

    task automatic test_faults();
        logic [31:0] got;
        do_access(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h0, 1, got);
        do_access(1'b1, 2'b01, 1'b0, 32'h1001, 32'h1234, 32'h0, 1, got);
        do_access(1'b0, 2'b11, 1'b1, 32'h1000, 32'h0, 32'h0, 1, got);
    endtask

    task automatic test_ignored_ack();
        for (int i = 0; i < 3; i++) begin
            bus_ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({req_ready, rsp_valid, bus_req} !== 3'b100) begin
                failures++;
                $display("FAIL idle_ack act=%b%b%b exp=100",
                         req_ready, rsp_valid, bus_req);
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                      $urandom, $urandom, int'($urandom_range(1, 4)), got);
        end
    endtask

    task automatic test_timeout();
        start_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0);
`ifdef LSU_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus_req !== 1'b1) begin
                failures++;
                $display("FAIL to_wait cyc=%0d act=%b exp=1", i, bus_req);
            end
            @(negedge clk);
        end
        checks++;
        if ({bus_req, rsp_valid, exception} !== 3'b011 || rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL to_rsp act=%b%b%b/%h exp=011/0",
                     bus_req, rsp_valid, exception, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL to_ready act=%b%b exp=10", req_ready, rsp_valid);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            checks++;
            if ({bus_req, rsp_valid} !== 2'b10) begin
                failures++;
                $display("FAIL no_to cyc=%0d act=%b%b exp=10", i, bus_req, rsp_valid);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 2'b00, 1'b1, 32'h3001, 32'h0);
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy act=%b exp=1", bus_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_req, rsp_valid, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL mid_reset act=%b%b%b exp=001",
                     bus_req, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            checks++;
            if ({req_ready, rsp_valid, bus_req} !== 3'b100) begin
                failures++;
                $display("FAIL mid_after cyc=%0d act=%b%b%b exp=100",
                         i, req_ready, rsp_valid, bus_req);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        do_access(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hCAFEF00D, 1, got);
        checks++;
        if (got !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_word act=%h exp=cafef00d", got);
        end
        do_access(1'b1, 2'b00, 1'b0, 32'h4002, 32'h000000A5, 32'h0, 1, got);
        do_access(1'b0, 2'b01, 1'b0, 32'h4002, 32'h0, 32'h8001FFFF, 1, got);
        checks++;
        if (got !== 32'h00008001) begin
            failures++;
            $display("FAIL b2b_lhu act=%h exp=00008001", got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_faults();
        test_ignored_ack();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
